// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding a UART transmitter with frame-spaced
// one-cycle start pulses.
//
// Ports:
//   sclk, rst             - system clock, synchronous active-high reset
//   wr_en, wr_data        - host write strobe and byte
//   full, empty, count    - registered FIFO status and occupancy
//   ovf                   - one-cycle pulse after a dropped write
//   tx_trig, tx_data      - transmitter start pulse and byte
//   busy                  - FIFO non-empty or sequencer active
module uart_tx_buf #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int FRAME_CYCLES = 52100
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          tx_trig,
  output logic [7:0]    tx_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          trig_q, trig_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   frm_q, frm_d;
  logic          push, pop;

  // Acceptance uses registered full, so a pop in the
  // same cycle cannot make room for a write at full.
  assign push = wr_en & ~full_q;
  assign pop  = (state_q == S_LOAD);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!empty_q) state_d = S_LOAD;
      S_LOAD: state_d = S_TRIG;
      S_TRIG: state_d = S_WAIT;
      S_WAIT: begin
        if (frm_q == 16'd0) begin
          state_d = empty_q ? S_IDLE : S_LOAD;
        end
      end
    endcase
  end

  always_comb begin
    trig_d = (state_d == S_TRIG);
    data_d = pop ? mem_q[rp_q] : data_q;
    frm_d  = frm_q;
    if (state_q == S_TRIG) begin
      frm_d = 16'(FRAME_CYCLES - 1);
    end else if (state_q == S_WAIT && frm_q != 16'd0) begin
      frm_d = frm_q - 16'd1;
    end
  end

  always_comb begin
    wp_d    = push ? wp_q + AW'(1) : wp_q;
    rp_d    = pop  ? rp_q + AW'(1) : rp_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
    ovf_d   = wr_en & full_q;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      trig_q  <= 1'b0;
      data_q  <= 8'h00;
      frm_q   <= 16'd0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      trig_q  <= trig_d;
      data_q  <= data_d;
      frm_q   <= frm_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = cnt_q;
  assign ovf     = ovf_q;
  assign tx_trig = trig_q;
  assign tx_data = data_q;
  assign busy    = (state_q != S_IDLE) | ~empty_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: randomized and directed bench for uart_tx_buf,
// checked every cycle against a queue-based reference model.
module tb_uart_tx_buf;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FC    = 20;
  localparam int SP    = FC + 2;

  logic          sclk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, ovf, tx_trig, busy;
  logic [AW:0]   count;
  logic [7:0]    tx_data;

  uart_tx_buf #(
    .DEPTH(DEPTH),
    .AW(AW),
    .FRAME_CYCLES(FC)
  ) dut (
    .sclk(sclk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .ovf(ovf),
    .tx_trig(tx_trig),
    .tx_data(tx_data),
    .busy(busy)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a byte leaves the queue on edge p when at least SP edges
  // have passed since the previous departure and the queue already
  // held data two edges earlier.
  int          n = 0;
  int          last_pop = -1000;
  int          c1 = 0;
  int          c2 = 0;
  logic [7:0]  mq[$];
  logic [7:0]  m_data = 8'h00;
  logic        m_ovf = 1'b0;
  logic [7:0]  sent[$];
  int          ovf_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               tag, obs, exp, n);
    end
  endtask

  task automatic step(input logic we, input logic [7:0] d,
                      input logic r);
    logic pop_now, push_now;
    wr_en = we;
    wr_data = d;
    rst = r;
    @(posedge sclk);
    n++;
    if (r) begin
      mq.delete();
      c1 = 0;
      c2 = 0;
      last_pop = -1000;
      m_data = 8'h00;
      m_ovf = 1'b0;
    end else begin
      pop_now  = (n - last_pop >= SP) && (c2 > 0);
      push_now = we && (c1 < DEPTH);
      m_ovf    = we && (c1 == DEPTH);
      if (pop_now) begin
        if (mq.size() == 0) begin
          chk("model_q", 32'd0, 32'd1);
        end else begin
          m_data = mq.pop_front();
        end
        last_pop = n;
      end
      if (push_now) mq.push_back(d);
      c2 = c1;
      c1 = mq.size();
    end
    @(negedge sclk);
    chk("count", 32'(count), 32'(c1));
    chk("full", 32'(full), 32'(c1 == DEPTH));
    chk("empty", 32'(empty), 32'(c1 == 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("tx_trig", 32'(tx_trig), 32'(last_pop == n));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("busy", 32'(busy), 32'((c1 > 0) || (n - last_pop <= FC)));
    if (tx_trig) sent.push_back(tx_data);
    if (ovf) ovf_n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (c1 == 0 && (n - last_pop > FC + 1)) break;
      step(1'b0, 8'h00, 1'b0);
    end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_sent(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, 32'(sent.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < sent.size(); i++) begin
      chk({tag, "_byte"}, 32'(sent[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] in_q[$];
    logic [7:0] b;
    int         t_trig;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_txdata", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);

    // single byte
    sent.delete();
    step(1'b1, 8'hA5, 1'b0);
    t_trig = n;
    idle(1);
    chk("single_notrig_e1", 32'(tx_trig), 32'd0);
    idle(1);
    chk("single_trig_e2", 32'(tx_trig), 32'd1);
    chk("single_data", 32'(tx_data), 32'hA5);
    t_trig = n;
    idle(20);
    chk("single_busy_20", 32'(busy), 32'd1);
    idle(1);
    chk("single_busy_21", 32'(busy), 32'd0);
    idle(5);
    exp_q = '{8'hA5};
    chk_sent("single", exp_q);

    // burst
    sent.delete();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    drain();
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_sent("burst", exp_q);

    // fill and overflow
    sent.delete();
    ovf_n = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 16) chk("fill_full", 32'(full), 32'd1);
    end
    drain();
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    chk_sent("fill", exp_q);
    chk("fill_ovf_pulses", 32'(ovf_n), 32'd1);

    // pointer wrap
    sent.delete();
    in_q.delete();
    for (int i = 0; i < 4000 && in_q.size() < 40; i++) begin
      if (c1 < 14 && $urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        in_q.push_back(b);
        step(1'b1, b, 1'b0);
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
    end
    drain();
    chk_sent("wrap", in_q);

    // write on the LOAD edge with count 5
    sent.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 60; i++) begin
      if ((n + 1 - last_pop >= SP) && c1 > 0) break;
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b1, 8'hC3, 1'b0);
    chk("simul_count", 32'(count), 32'd5);
    drain();
    exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'hC3};
    chk_sent("simul", exp_q);

    // reset ten cycles into WAIT
    sent.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (n - last_pop == 10) break;
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("rmid_count", 32'(count), 32'd0);
    chk("rmid_empty", 32'(empty), 32'd1);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_data", 32'(tx_data), 32'h00);
    idle(60);
    exp_q = '{8'h70};
    chk_sent("rmid", exp_q);
    step(1'b1, 8'h5A, 1'b0);
    drain();
    exp_q = '{8'h70, 8'h5A};
    chk_sent("rmid_after", exp_q);

    // random soak with occasional reset
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 199) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
